// File: rtl/nx_ctrl_bridge.sv
// Byte-stream to word bridge between a host byte link and a controller word port.
// Inbound bytes assemble MSB-first into words; outbound response words serialise MSB-first.
module nx_ctrl_bridge #(
    parameter int MESSAGE_WIDTH = 32,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o,
    output logic [MESSAGE_WIDTH-1:0] ctrl_data_o,
    output logic                     ctrl_valid_o,
    input  logic                     ctrl_ready_i,
    input  logic [MESSAGE_WIDTH-1:0] resp_data_i,
    input  logic                     resp_valid_i,
    output logic                     resp_ready_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [7:0]               timeout_count_o,
    output logic                     dbg_tx_state_o
);

    localparam int BYTES = MESSAGE_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    // Every handshake transfers only when valid and ready are both high in the same cycle;
    // the source holds valid and data stable until that cycle.

    // ---------------- inbound assembly ----------------
    logic [MESSAGE_WIDTH-1:0] r_word;
    logic [MESSAGE_WIDTH-1:0] r_ctrl_data;
    logic                     r_ctrl_valid;
    logic [IDX_W-1:0]         r_byte_idx;
    logic [CNT_W-1:0]         r_idle_cnt;
    logic [7:0]               r_timeout_cnt;

    logic                     w_rx_accept;
    logic                     w_rx_last;
    logic                     w_timeout;
    logic [MESSAGE_WIDTH-1:0] w_word_next;

    assign w_rx_accept = rx_valid_i && !r_ctrl_valid;
    assign w_rx_last   = (r_byte_idx == LAST_IDX);
    assign w_word_next = {r_word[MESSAGE_WIDTH-9:0], rx_data_i};
    // An accepted byte wins over an expiring idle counter.
    assign w_timeout   = (r_byte_idx != '0) && (r_idle_cnt == TO_LAST) && !w_rx_accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word        <= '0;
            r_ctrl_data   <= '0;
            r_ctrl_valid  <= 1'b0;
            r_byte_idx    <= '0;
            r_idle_cnt    <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (r_ctrl_valid && ctrl_ready_i) begin
                r_ctrl_valid <= 1'b0;
            end
            if (w_rx_accept) begin
                r_idle_cnt <= '0;
                if (w_rx_last) begin
                    r_word       <= '0;
                    r_ctrl_data  <= w_word_next;
                    r_ctrl_valid <= 1'b1;
                    r_byte_idx   <= '0;
                end else begin
                    r_word     <= w_word_next;
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
            end else if (w_timeout) begin
                r_word     <= '0;
                r_byte_idx <= '0;
                r_idle_cnt <= '0;
                if (r_timeout_cnt != 8'hFF) begin
                    r_timeout_cnt <= r_timeout_cnt + 8'd1;
                end
            end else if (r_byte_idx == '0) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
        end
    end

    assign rx_ready_o      = rst_i || !r_ctrl_valid;
    assign ctrl_data_o     = r_ctrl_data;
    assign ctrl_valid_o    = r_ctrl_valid;
    assign timeout_count_o = r_timeout_cnt;

    // ---------------- outbound serialiser ----------------
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    tx_state_t                r_tx_state;
    tx_state_t                w_tx_state_next;
    logic [MESSAGE_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]         r_tx_idx;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_resp_ready;
    logic                     w_tx_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_state <= TX_IDLE;
            r_shift    <= '0;
            r_tx_idx   <= '0;
        end else begin
            r_tx_state <= w_tx_state_next;
            if (w_load) begin
                r_shift  <= resp_data_i;
                r_tx_idx <= '0;
            end else if (w_shift) begin
                r_shift  <= {r_shift[MESSAGE_WIDTH-9:0], 8'h00};
                r_tx_idx <= (r_tx_idx == LAST_IDX) ? '0 : r_tx_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_resp_ready    = 1'b0;
        w_tx_valid      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_resp_ready = 1'b1;
                if (resp_valid_i) begin
                    w_load          = 1'b1;
                    w_tx_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                w_tx_valid = 1'b1;
                if (tx_ready_i) begin
                    w_shift = 1'b1;
                    if (r_tx_idx == LAST_IDX) begin
                        w_tx_state_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    assign resp_ready_o   = rst_i || w_resp_ready;
    assign tx_valid_o     = w_tx_valid;
    assign tx_data_o      = r_shift[MESSAGE_WIDTH-1 -: 8];
    assign dbg_tx_state_o = r_tx_state;

endmodule

// File: tb/tb_nx_ctrl_bridge.sv
// Directed bench for nx_ctrl_bridge: assembly, backpressure, timeout, serialisation, reset.
module tb_nx_ctrl_bridge;

    localparam int W  = 32;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic [W-1:0]  ctrl_data_o;
    logic          ctrl_valid_o;
    logic          ctrl_ready_i;
    logic [W-1:0]  resp_data_i;
    logic          resp_valid_i;
    logic          resp_ready_o;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic [7:0]    timeout_count_o;
    logic          dbg_tx_state_o;

    int checks   = 0;
    int failures = 0;

    nx_ctrl_bridge #(.MESSAGE_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rx_data_i       (rx_data_i),
        .rx_valid_i      (rx_valid_i),
        .rx_ready_o      (rx_ready_o),
        .ctrl_data_o     (ctrl_data_o),
        .ctrl_valid_o    (ctrl_valid_o),
        .ctrl_ready_i    (ctrl_ready_i),
        .resp_data_i     (resp_data_i),
        .resp_valid_i    (resp_valid_i),
        .resp_ready_o    (resp_ready_o),
        .tx_data_o       (tx_data_o),
        .tx_valid_o      (tx_valid_o),
        .tx_ready_i      (tx_ready_i),
        .timeout_count_o (timeout_count_o),
        .dbg_tx_state_o  (dbg_tx_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One byte then a full idle window: exactly one discard.
    task automatic force_timeout();
        send_byte(8'h5A);
        idle(TO);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   tx_exp [4];
        logic [W-1:0] held;

        rst_i        = 1'b1;
        rx_data_i    = 8'h00;
        rx_valid_i   = 1'b0;
        ctrl_ready_i = 1'b1;
        resp_data_i  = '0;
        resp_valid_i = 1'b0;
        tx_ready_i   = 1'b0;
        idle(3);
        chk("rst_ctrl_valid", {31'd0, ctrl_valid_o}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("rst_resp_ready", {31'd0, resp_ready_o}, 32'd1);
        chk("rst_timeouts", {24'd0, timeout_count_o}, 32'd0);
        chk("rst_ctrl_data", ctrl_data_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic assembly with ready high: one-cycle valid pulse.
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        chk("asm_not_yet", {31'd0, ctrl_valid_o}, 32'd0);
        send_byte(8'h78);
        chk("asm_valid", {31'd0, ctrl_valid_o}, 32'd1);
        chk("asm_data", ctrl_data_o, 32'h12345678);
        chk("asm_rx_blocked", {31'd0, rx_ready_o}, 32'd0);
        tick();
        chk("asm_valid_clear", {31'd0, ctrl_valid_o}, 32'd0);
        chk("asm_rx_ready", {31'd0, rx_ready_o}, 32'd1);

        // Backpressure: word held for 10 cycles.
        ctrl_ready_i = 1'b0;
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        held = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rx_ready", {31'd0, rx_ready_o}, 32'd0);
            chk("bp_valid", {31'd0, ctrl_valid_o}, 32'd1);
            chk("bp_data", ctrl_data_o, held);
            tick();
        end
        ctrl_ready_i = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, ctrl_valid_o}, 32'd0);
        chk("bp_release_ready", {31'd0, rx_ready_o}, 32'd1);

        // Timeout: two bytes then silence; discard happens on the TIMEOUT-th idle edge.
        send_byte(8'h01);
        send_byte(8'h02);
        idle(TO - 1);
        chk("to_before", {24'd0, timeout_count_o}, 32'd0);
        tick();
        chk("to_after", {24'd0, timeout_count_o}, 32'd1);
        idle(2);
        chk("to_no_emit", {31'd0, ctrl_valid_o}, 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("to_clean_valid", {31'd0, ctrl_valid_o}, 32'd1);
        chk("to_clean_data", ctrl_data_o, 32'hAABBCCDD);
        chk("to_count_kept", {24'd0, timeout_count_o}, 32'd1);
        tick();

        // A byte arriving exactly on the expiry cycle is kept.
        send_byte(8'h11);
        idle(TO - 1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("prio_valid", {31'd0, ctrl_valid_o}, 32'd1);
        chk("prio_data", ctrl_data_o, 32'h11223344);
        chk("prio_count", {24'd0, timeout_count_o}, 32'd1);
        tick();

        // Outbound serialisation with tx_ready toggling.
        tx_exp[0] = 8'h0A;
        tx_exp[1] = 8'h0B;
        tx_exp[2] = 8'h0C;
        tx_exp[3] = 8'h0D;
        chk("tx_idle_ready", {31'd0, resp_ready_o}, 32'd1);
        resp_data_i  = 32'h0A0B0C0D;
        resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        resp_data_i  = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            chk("tx_valid", {31'd0, tx_valid_o}, 32'd1);
            chk("tx_byte", {24'd0, tx_data_o}, {24'd0, tx_exp[i]});
            chk("tx_resp_busy", {31'd0, resp_ready_o}, 32'd0);
            tx_ready_i = 1'b0;
            tick();
            chk("tx_byte_hold", {24'd0, tx_data_o}, {24'd0, tx_exp[i]});
            tx_ready_i = 1'b1;
            tick();
        end
        tx_ready_i = 1'b0;
        chk("tx_done_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("tx_done_ready", {31'd0, resp_ready_o}, 32'd1);

        // Saturation: 300 further timeouts.
        for (int i = 0; i < 253; i++) force_timeout();
        chk("sat_254", {24'd0, timeout_count_o}, 32'd254);
        for (int i = 0; i < 47; i++) force_timeout();
        chk("sat_255", {24'd0, timeout_count_o}, 32'd255);

        // Reset mid-word on both paths.
        resp_data_i  = 32'hCAFEF00D;
        resp_valid_i = 1'b1;
        send_byte(8'h55);
        resp_valid_i = 1'b0;
        tx_ready_i   = 1'b1;
        chk("mid_tx_first", {24'd0, tx_data_o}, 32'hCA);
        send_byte(8'h66);
        send_byte(8'h77);
        tx_ready_i = 1'b0;
        chk("mid_tx_third", {24'd0, tx_data_o}, 32'hF0);
        rst_i      = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h99;
        tick();
        tick();
        chk("mid_rst_ctrl_valid", {31'd0, ctrl_valid_o}, 32'd0);
        chk("mid_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("mid_rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("mid_rst_resp_ready", {31'd0, resp_ready_o}, 32'd1);
        chk("mid_rst_timeouts", {24'd0, timeout_count_o}, 32'd0);
        rst_i      = 1'b0;
        rx_valid_i = 1'b0;
        tick();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("post_rst_tx_quiet", {31'd0, tx_valid_o}, 32'd0);
        send_byte(8'h04);
        chk("post_rst_valid", {31'd0, ctrl_valid_o}, 32'd1);
        chk("post_rst_data", ctrl_data_o, 32'h01020304);
        chk("post_rst_tx_idle", {31'd0, tx_valid_o}, 32'd0);
        chk("post_rst_timeouts", {24'd0, timeout_count_o}, 32'd0);
        tick();
        chk("post_rst_clear", {31'd0, ctrl_valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
